line_fill_demux: RTL and testbench
==================================

# line_fill_demux

Write-side counterpart to the way-select multiplexor in the L2 data array. It assembles a full cache line from narrow beats returned by the next memory level. It then writes that line into exactly one way of the addressed set by driving a broadcast line bus plus a one-hot per-way write enable. It sits between the fill/return path and the set storage, and is the single writer of the data array on line fills.

## Interface
Parameters:
- lineSize, 512, line width in bits
- ways, 8, associativity; width of way_we
- beatWidth, 64, width of one returned data beat; lineSize must be an integer multiple of beatWidth (beats = lineSize / beatWidth)

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request a fill; sampled only in IDLE
- way  input  $clog2(ways)  target way; latched when start is accepted
- beat_valid  input  1  beat_data holds a valid beat
- beat_data  input  beatWidth  fill data beat
- beat_ready  output  1  block accepts a beat this cycle
- busy  output  1  fill in progress (FILL or WRITE)
- line_out  output  lineSize  assembled line, broadcast to all ways
- way_we  output  ways  one-hot write enable into the set storage
- done  output  1  single-cycle pulse, coincident with way_we

## Operation
- Registered state: FSM state, latched way, beat counter ($clog2(beats) bits, min 1), line buffer.
- States:
  - IDLE: beat_ready=0, busy=0, way_we=0, done=0. start=1 latches way, clears the counter and moves to FILL.
  - FILL: beat_ready=1, busy=1. A beat is accepted when beat_valid && beat_ready. An accepted beat is written to line buffer bits [cnt*beatWidth +: beatWidth] and cnt is incremented. Beat 0 is least significant. When the beat accepted has cnt == beats-1, the FSM moves to WRITE. Without beat_valid, FILL holds with no timeout.
  - WRITE: beat_ready=0, busy=1, done=1. way_we = one-hot of the latched way. The FSM then moves unconditionally to IDLE.
- Out-of-range way: if the latched way >= ways (non-power-of-two ways), way_we is all-zero in WRITE. done still pulses.
- line_out is the line buffer register, driven continuously. It holds the last assembled line until beats of the next fill overwrite it. Beats not yet received in a new fill retain stale data. This is safe because way_we is low outside WRITE.
- start while busy=1 is ignored; it is not queued.
- beat_valid in IDLE or WRITE is ignored. The beat is not consumed and the buffer is unchanged.
- Reset (reset_n=0 on a clock edge, any state, including mid-FILL): state=IDLE, counter=0, latched way=0, line buffer=0. No way_we is issued for the aborted fill.

## Timing
- Reset values: beat_ready=0, busy=0, way_we=0, done=0, line_out=0.
- All outputs are registered-state decodes. There is no combinational path from inputs to outputs.
- start accepted at edge t: FILL from t+1; beat_ready is high in cycle t+1.
- With back-to-back beats (beats=8), beats are accepted at edges t+1..t+8. WRITE is cycle t+9, with way_we and done high for that cycle only. IDLE is at t+10, and the next start is accepted at edge t+10 at the earliest.
- Minimum fill-to-fill period: beats+2 cycles.
- Stalls (beat_valid=0) extend FILL cycle-for-cycle. WRITE always lasts exactly 1 cycle.
- line_out is stable and equal to the full assembled line throughout the WRITE cycle.

## Test plan
- Basic fill: reset, start with way=5, 8 back-to-back beats 64'h0..07 (beat i = i) -> one cycle of way_we=8'b0010_0000 and done=1 at start+9; line_out = {64'h7,...,64'h0}; beat_ready low in that cycle.
- Stalled beats: same fill with beat_valid low for 3 cycles between beats 2 and 3 -> WRITE occurs at start+12; line contents identical; no extra beats consumed.
- Ignored inputs: pulse start with way=1 during FILL, and beat_valid=1 in IDLE -> latched way stays 5; way_we=8'b0010_0000; IDLE beat not captured (line_out unchanged before start).
- Reset mid-fill: assert reset_n=0 after 4 beats -> next cycle busy=0, beat_ready=0, line_out=0; way_we never asserts. A subsequent full fill to way 0 gives way_we=8'b0000_0001.
- Back-to-back fills: start on the first IDLE cycle after done, ways 7 then 0 -> two way_we pulses 10 cycles apart, each exactly one-hot, each with the correct line_out.
- Parameter sweep: ways=6, beatWidth=128 (4 beats); fill with way=7 -> done pulses at start+5 and way_we=6'b0; fill with way=2 -> way_we=6'b000100.

Source files
------------

// File: rtl/line_fill_demux_if.sv
// line_fill_demux_if
// Bundles the fill-side handshake and the write-side line bus of the
// line fill demultiplexor.
//   master : the fill requester / memory return path (drives start, way,
//            beat_valid, beat_data; observes everything else)
//   slave  : the line_fill_demux block itself
// Signals:
//   start      request a fill (only looked at while idle)
//   way        target way, captured when a fill starts
//   beat_valid beat_data carries a valid beat
//   beat_data  one narrow data beat from the next memory level
//   beat_ready block takes a beat this cycle
//   busy       fill or line write in progress
//   line_out   assembled line, broadcast to every way
//   way_we     one-hot write enable into the set storage
//   done       one-cycle pulse alongside way_we
interface line_fill_demux_if #(
    parameter int lineSize  = 512,
    parameter int ways      = 8,
    parameter int beatWidth = 64
);
    localparam int wayW = (ways > 1) ? $clog2(ways) : 1;

    logic                 start;
    logic [wayW-1:0]      way;
    logic                 beat_valid;
    logic [beatWidth-1:0] beat_data;
    logic                 beat_ready;
    logic                 busy;
    logic [lineSize-1:0]  line_out;
    logic [ways-1:0]      way_we;
    logic                 done;

    modport master (
        output start, way, beat_valid, beat_data,
        input  beat_ready, busy, line_out, way_we, done
    );

    modport slave (
        input  start, way, beat_valid, beat_data,
        output beat_ready, busy, line_out, way_we, done
    );
endinterface

// File: rtl/line_fill_demux.sv
// line_fill_demux
// Collects lineSize/beatWidth narrow beats from the memory return path into
// a line buffer, then writes that line into exactly one way of the addressed
// set with a single-cycle one-hot write enable. It is the only writer of the
// data array during line fills.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      line_fill_demux_if slave modport (handshake, beats, line bus,
//            way_we, done)
// Every output is a register, so no input reaches an output combinationally.
module line_fill_demux #(
    parameter int lineSize  = 512,
    parameter int ways      = 8,
    parameter int beatWidth = 64
) (
    input logic               clock,
    input logic               reset_n,
    line_fill_demux_if.slave  bus
);
    localparam int beats = lineSize / beatWidth;
    localparam int cntW  = (beats > 1) ? $clog2(beats) : 1;
    localparam int wayW  = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t              state_q;
    logic [wayW-1:0]     way_q;
    logic [cntW-1:0]     cnt_q;
    logic [cntW-1:0]     cnt_d;
    logic [lineSize-1:0] line_q;
    logic [lineSize-1:0] line_d;
    logic                beat_ready_q;
    logic                busy_q;
    logic                done_q;
    logic [ways-1:0]     way_we_q;
    logic [ways-1:0]     wayOneHot;
    logic                beatAccept;
    logic                lastBeat;

    // Beat datapath: beat_ready_q is only high in FILL, so it doubles as the
    // state qualifier and beats offered in IDLE or WRITE are never taken.
    always_comb begin
        beatAccept = bus.beat_valid && beat_ready_q;
        lastBeat   = (cnt_q == cntW'(beats - 1));
        cnt_d      = cnt_q;
        line_d     = line_q;
        if (beatAccept) begin
            line_d[int'(cnt_q) * beatWidth +: beatWidth] = bus.beat_data;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // One-hot decode of the latched way. A way index beyond the last real
    // way (non-power-of-two associativity) matches nothing and yields zero.
    always_comb begin
        wayOneHot = '0;
        for (int i = 0; i < ways; i++) begin
            wayOneHot[i] = (int'(way_q) == i);
        end
    end

    // Control FSM with registered outputs. Outputs are loaded on the edge
    // that enters each state, so they line up exactly with the state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            way_q        <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            beat_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            way_we_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        way_q        <= bus.way;
                        cnt_q        <= '0;
                        state_q      <= FILL;
                        beat_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                FILL: begin
                    if (beatAccept) begin
                        cnt_q  <= cnt_d;
                        line_q <= line_d;
                        if (lastBeat) begin
                            state_q      <= WRITE;
                            beat_ready_q <= 1'b0;
                            way_we_q     <= wayOneHot;
                            done_q       <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    way_we_q <= '0;
                    done_q   <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    beat_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    way_we_q     <= '0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.beat_ready = beat_ready_q;
    assign bus.busy       = busy_q;
    assign bus.line_out   = line_q;
    assign bus.way_we     = way_we_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_line_fill_demux.sv
// tb_line_fill_demux
// Directed bench for line_fill_demux. Instance A uses the default geometry
// (512-bit line, 8 ways, 64-bit beats); instance B uses 6 ways and 128-bit
// beats to cover non-power-of-two associativity and an out-of-range way.
module tb_line_fill_demux;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    line_fill_demux_if #(.lineSize(512), .ways(8), .beatWidth(64))  busA ();
    line_fill_demux_if #(.lineSize(512), .ways(6), .beatWidth(128)) busB ();

    line_fill_demux #(.lineSize(512), .ways(8), .beatWidth(64)) dutA (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (busA)
    );

    line_fill_demux #(.lineSize(512), .ways(6), .beatWidth(128)) dutB (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (busB)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int weCycle = 0;
    int firstWe = 0;

    // Free-running edge counter used to time the write pulses.
    always @(posedge clock) cyc <= cyc + 1;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line for instance A where beat i carries base+i.
    function automatic logic [511:0] lineA(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    // Line for instance B where beat i carries base+i.
    function automatic logic [511:0] lineB(input logic [127:0] base);
        logic [511:0] l;
        for (int i = 0; i < 4; i++) l[i*128 +: 128] = base + 128'(i);
        return l;
    endfunction

    // One fill on instance A, starting from an IDLE cycle. Optional stall
    // between beats 2 and 3 and an optional stray start pulse during FILL.
    task automatic applyStimulusA(input logic [2:0] w, input logic [63:0] base, input int stallLen,
                                  input bit pulseStart, input logic [7:0] expWe, input string tag);
        int startCyc;
        busA.start      = 1'b1;
        busA.way        = w;
        busA.beat_valid = 1'b0;
        step();
        startCyc   = cyc;
        busA.start = 1'b0;
        checkOutput({tag, "_fillReady"}, 512'(busA.beat_ready), 512'(1));
        checkOutput({tag, "_fillBusy"}, 512'(busA.busy), 512'(1));
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int s = 0; s < stallLen; s++) begin
                    busA.beat_valid = 1'b0;
                    busA.beat_data  = 64'hBAD0_BAD0_BAD0_BAD0;
                    step();
                end
            end
            busA.start      = pulseStart && (i == 2);
            busA.way        = pulseStart ? 3'd1 : w;
            busA.beat_valid = 1'b1;
            busA.beat_data  = base + 64'(i);
            if (i == 7) checkOutput({tag, "_doneEarly"}, 512'(busA.done), 512'(0));
            step();
        end
        busA.beat_valid = 1'b0;
        busA.start      = 1'b0;
        weCycle = cyc;
        checkOutput({tag, "_writeTime"}, 512'(cyc - startCyc), 512'(8 + stallLen));
        checkOutput({tag, "_wayWe"}, 512'(busA.way_we), 512'(expWe));
        checkOutput({tag, "_done"}, 512'(busA.done), 512'(1));
        checkOutput({tag, "_writeReady"}, 512'(busA.beat_ready), 512'(0));
        checkOutput({tag, "_line"}, busA.line_out, lineA(base));
        step();
        checkOutput({tag, "_idleWe"}, 512'(busA.way_we), 512'(0));
        checkOutput({tag, "_idleDone"}, 512'(busA.done), 512'(0));
        checkOutput({tag, "_idleBusy"}, 512'(busA.busy), 512'(0));
    endtask

    // One fill on instance B (4 beats of 128 bits).
    task automatic applyStimulusB(input logic [2:0] w, input logic [127:0] base,
                                  input logic [5:0] expWe, input string tag);
        int startCyc;
        busB.start = 1'b1;
        busB.way   = w;
        step();
        startCyc   = cyc;
        busB.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            busB.beat_valid = 1'b1;
            busB.beat_data  = base + 128'(i);
            if (i == 3) checkOutput({tag, "_doneEarly"}, 512'(busB.done), 512'(0));
            step();
        end
        busB.beat_valid = 1'b0;
        checkOutput({tag, "_writeTime"}, 512'(cyc - startCyc), 512'(4));
        checkOutput({tag, "_done"}, 512'(busB.done), 512'(1));
        checkOutput({tag, "_wayWe"}, 512'(busB.way_we), 512'(expWe));
        checkOutput({tag, "_line"}, busB.line_out, lineB(base));
        step();
        checkOutput({tag, "_idleDone"}, 512'(busB.done), 512'(0));
    endtask

    initial begin
        reset_n         = 1'b0;
        busA.start      = 1'b0;
        busA.way        = '0;
        busA.beat_valid = 1'b0;
        busA.beat_data  = '0;
        busB.start      = 1'b0;
        busB.way        = '0;
        busB.beat_valid = 1'b0;
        busB.beat_data  = '0;
        step();
        step();
        step();

        // Reset state
        checkOutput("rst_ready", 512'(busA.beat_ready), 512'(0));
        checkOutput("rst_busy", 512'(busA.busy), 512'(0));
        checkOutput("rst_wayWe", 512'(busA.way_we), 512'(0));
        checkOutput("rst_done", 512'(busA.done), 512'(0));
        checkOutput("rst_line", busA.line_out, 512'(0));
        checkOutput("rstB_line", busB.line_out, 512'(0));

        // Beats offered while idle are not taken
        reset_n         = 1'b1;
        busA.beat_valid = 1'b1;
        busA.beat_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        step();
        checkOutput("idleBeat_line", busA.line_out, 512'(0));
        checkOutput("idleBeat_ready", 512'(busA.beat_ready), 512'(0));
        busA.beat_valid = 1'b0;

        // Basic fill, stalled fill, fill with a stray start pulse
        applyStimulusA(3'd5, 64'h0, 0, 1'b0, 8'b0010_0000, "basic");
        applyStimulusA(3'd5, 64'h0, 3, 1'b0, 8'b0010_0000, "stall");
        applyStimulusA(3'd5, 64'h20, 0, 1'b1, 8'b0010_0000, "ignore");

        // Idle beat after a fill leaves the previous line intact
        busA.beat_valid = 1'b1;
        busA.beat_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        busA.beat_valid = 1'b0;
        checkOutput("idleBeat2_line", busA.line_out, lineA(64'h20));

        // Reset after four beats aborts the fill
        busA.start = 1'b1;
        busA.way   = 3'd3;
        step();
        busA.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            busA.beat_valid = 1'b1;
            busA.beat_data  = 64'h40 + 64'(i);
            step();
        end
        busA.beat_valid = 1'b0;
        reset_n = 1'b0;
        step();
        checkOutput("midRst_busy", 512'(busA.busy), 512'(0));
        checkOutput("midRst_ready", 512'(busA.beat_ready), 512'(0));
        checkOutput("midRst_line", busA.line_out, 512'(0));
        checkOutput("midRst_wayWe", 512'(busA.way_we), 512'(0));
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("postRst_wayWe", 512'(busA.way_we), 512'(0));
        end
        applyStimulusA(3'd0, 64'h50, 0, 1'b0, 8'b0000_0001, "afterRst");

        // Back-to-back fills, second start in the first idle cycle
        applyStimulusA(3'd7, 64'h60, 0, 1'b0, 8'b1000_0000, "b2b0");
        firstWe = weCycle;
        applyStimulusA(3'd0, 64'h70, 0, 1'b0, 8'b0000_0001, "b2b1");
        checkOutput("b2b_gap", 512'(weCycle - firstWe), 512'(10));

        // Six-way, four-beat instance: out-of-range way then way 2
        applyStimulusB(3'd7, 128'h1000, 6'b000000, "oorWay");
        applyStimulusB(3'd2, 128'h2000, 6'b000100, "way2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
